// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, frame shape and elaboration-time
// parameter checks reused by the transmit arbiter and the receiver.
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_CHECK_NREQ(N_) \
  if ((N_) < 1) begin : g_bad_nreq \
    $fatal(1, "uart: NREQ must be at least 1"); \
  end

`define UART_CHECK_RATE(CLKF_, BR_) \
  if ((CLKF_) == 0 || (BR_) == 0) begin : g_bad_zero \
    $fatal(1, "uart: CLKF and BR must be nonzero"); \
  end else if ((CLKF_) < 2 * (BR_)) begin : g_bad_ratio \
    $fatal(1, "uart: CLKF must be at least 2*BR"); \
  end else if (((CLKF_) % (BR_)) != 0) begin : g_bad_div \
    $fatal(1, "uart: CLKF must be a multiple of BR"); \
  end

package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

`endif

// File: rtl/uart_bit_timer.sv
// Clock-enable style bit timer: counts 0..CPB-1 and flags the last clock of a bit.
module uart_bit_timer #(
  parameter int CPB = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);
  localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // restart holds the count at zero so every state entry begins a full bit
  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done = (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmit line among NREQ byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int CLKF = 1_843_200,
  parameter  int BR   = 115_200,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id
);
  localparam int CPB = (BR > 0) ? (CLKF / BR) : 2;

  `UART_CHECK_NREQ(NREQ)
  `UART_CHECK_RATE(CLKF, BR)
  if (STOP_BITS != 1) begin : g_bad_stop
    $fatal(1, "uart_tx_arbiter: only one stop bit is supported");
  end

  uart_state_e    state_q;
  logic [IDW-1:0] ptr_q, grant_q, win_s, cand_s, ptr_next_s;
  logic           found_s, accept_s, restart_s, bit_done_s;
  logic [7:0]     shreg_q, win_byte_s;
  logic [2:0]     idx_q;
  logic           tx_q, busy_q;

  // Scan from ptr downward in priority so the lowest offset from ptr wins last
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s  = IDW'((int'(ptr_q) + k) % NREQ);
      win_s   = req_valid[cand_s] ? cand_s : win_s;
      found_s = found_s | req_valid[cand_s];
    end
  end

  always_comb begin
    win_byte_s = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      win_byte_s = (IDW'(k) == win_s) ? req_data[8*k +: 8] : win_byte_s;
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && !reset && found_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s   = (state_q == IDLE) && found_s;
  assign ptr_next_s = (win_s == IDW'(NREQ - 1)) ? '0 : (win_s + IDW'(1));
  assign restart_s  = (state_q == IDLE) || bit_done_s;

  uart_bit_timer #(.CPB(CPB)) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart_s),
    .bit_done (bit_done_s)
  );

  // Frame sequencer; tx is loaded one clock ahead so it changes with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      shreg_q <= 8'h00;
      idx_q   <= 3'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            shreg_q <= win_byte_s;
            grant_q <= win_s;
            ptr_q   <= ptr_next_s;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_done_s) begin
            idx_q   <= 3'd0;
            tx_q    <= shreg_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            if (idx_q == 3'(DATA_BITS - 1)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shreg_q[idx_q + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_done_s) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: frame-level reference model plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 4;
  localparam int CLKF  = 1_843_200;
  localparam int BR    = 115_200;
  localparam int CPB   = CLKF / BR;
  localparam int FRAME = 10 * CPB;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx, busy;
  logic [1:0]        grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_q[$];
  int gnt_q[$];

  // reference model: n = position inside the current frame (0 = idle)
  int         n = 0;
  logic [7:0] mbyte = 8'h00;
  int         mptr = 0;
  int         mgrant = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .CLKF(CLKF), .BR(BR)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic exp_tx(input int nn, input logic [7:0] b);
    int k;
    if (nn == 0) return 1'b1;
    k = (nn - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Model frame progress: a frame spans FRAME clocks after its accepting edge
  always @(posedge clk or posedge reset) begin
    int w;
    if (reset) begin
      n = 0;
      mptr = 0;
      mgrant = 0;
    end else if (n != 0) begin
      n = (n == FRAME) ? 0 : n + 1;
    end else begin
      w = rr_pick(req_valid, mptr);
      if (w >= 0) begin
        mbyte  = req_data[8*w +: 8];
        mgrant = w;
        mptr   = (w + 1) % NREQ;
        n      = 1;
      end
    end
  end

  // Every-cycle comparison against the model, plus acceptance logging
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int w;
    er = '0;
    if (!reset && n == 0) begin
      w = rr_pick(req_valid, mptr);
      if (w >= 0) er[w] = 1'b1;
    end
    chk("model_tx", 32'(tx), 32'(exp_tx(n, mbyte)));
    chk("model_busy", 32'(busy), 32'(n != 0));
    chk("model_ready", 32'(req_ready), 32'(er));
    chk("model_grant", 32'(grant_id), 32'(mgrant));
    if (!reset && ((req_valid & req_ready) != '0)) begin
      acc_q.push_back(cyc + 1);
      gnt_q.push_back(onehot_idx(req_ready));
    end
  end

  task automatic wait_acc(input int target, input int budget, input string nm);
    int t;
    t = 0;
    while (acc_q.size() < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    if (acc_q.size() < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, got %0d accepts expected %0d", nm, acc_q.size(), target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] sb;
    int         exp_order[5];
    sb = {1'b1, 8'hA5, 1'b0};
    exp_order = '{0, 1, 2, 3, 0};

    // reset values and quiet idle
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);

    // full load fairness
    @(posedge clk);
    #1 req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    wait_acc(5, 5 * (FRAME + 1) + 40, "fairness");
    #1 req_valid = 4'b1001;
    for (int i = 0; i < 5; i++) chk("fair_order", 32'(qget(gnt_q, i)), 32'(exp_order[i]));
    for (int i = 1; i < 5; i++) chk("fair_spacing", 32'(qget(acc_q, i) - qget(acc_q, i - 1)), 32'd161);

    // rotation after granting 0 with only 0 and 3 valid
    wait_acc(7, 2 * (FRAME + 1) + 10, "rotation");
    #1 req_valid = 4'b0000;
    chk("rot_first", 32'(qget(gnt_q, 5)), 32'd3);
    chk("rot_second", 32'(qget(gnt_q, 6)), 32'd0);
    chk("rot_spacing", 32'(qget(acc_q, 6) - qget(acc_q, 5)), 32'd161);

    // single byte 0xA5 from requester 1, data disturbed after acceptance
    req_data[15:8] = 8'hA5;
    req_valid = 4'b0010;
    wait_acc(8, FRAME + 20, "single");
    #1 req_valid = 4'b0000;
    req_data[15:8] = 8'h00;
    chk("single_grant_id", 32'(qget(gnt_q, 7)), 32'd1);
    for (int m = 0; m < FRAME; m++) begin
      @(negedge clk);
      chk("single_tx", 32'(tx), 32'(sb[m / CPB]));
      if (m == 0) chk("single_grant", 32'(grant_id), 32'd1);
    end
    @(negedge clk);
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_tx_end", 32'(tx), 32'd1);

    // reset during data bit 4, requester 2 stays valid
    @(posedge clk);
    #1 req_data[23:16] = 8'h0F;
    req_valid = 4'b0100;
    wait_acc(9, 40, "pre_reset");
    repeat (88) @(negedge clk);
    chk("bit4_tx", 32'(tx), 32'd0);
    chk("bit4_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_acc(10, 20, "post_reset");
    #1 req_valid = 4'b0000;
    chk("post_grant_id", 32'(qget(gnt_q, 9)), 32'd2);
    repeat (FRAME) @(negedge clk);
    chk("post_busy_last", 32'(busy), 32'd1);
    @(negedge clk);
    chk("post_busy_end", 32'(busy), 32'd0);
    chk("post_tx_end", 32'(tx), 32'd1);
    chk("post_grant", 32'(grant_id), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
